// File: rtl/dht_reader.sv
// DHT single-wire protocol engine: start pulse, response detect, 40-bit read, checksum check, bounded retry.
// Define CACHE_EN to serve repeat requests from the last good frame for MIN_INTERVAL_MS.
module dht_reader #(
  parameter int CLK_HZ          = 50000000,
  parameter int START_LOW_US    = 18000,
  parameter int BIT_THRESH_US   = 40,
  parameter int TIMEOUT_US      = 200,
  parameter int MAX_RETRIES     = 2,
  parameter int MIN_INTERVAL_MS = 2000
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  request,
  inout  wire         dht_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] result,
  output logic [7:0]  check_sum
);

  typedef enum logic [3:0] {
    IDLE, START_LOW, RELEASE, RESP_LOW, RESP_HIGH,
    BIT_LOW, BIT_HIGH, CHECK, RETRY_WAIT, DONE
  } state_t;

  localparam int US_DIV = (CLK_HZ / 1000000 > 0) ? CLK_HZ / 1000000 : 1;
  localparam int TICK_W = $clog2(US_DIV + 1);
  localparam int US_W   = 24;
  localparam logic [TICK_W-1:0] TICK_LAST    = TICK_W'(US_DIV - 1);
  localparam logic [US_W-1:0]   START_LAST   = US_W'(START_LOW_US - 1);
  localparam logic [US_W-1:0]   TIMEOUT_LAST = US_W'(TIMEOUT_US - 1);
  localparam logic [US_W-1:0]   RETRY_LAST   = US_W'(999);
  localparam logic [US_W-1:0]   THRESH       = US_W'(BIT_THRESH_US);
  localparam logic [7:0]        RETRY_MAX    = 8'(MAX_RETRIES);

  state_t            state, state_next;
  logic [2:0]        sync;
  logic              rise, fall;
  logic [TICK_W-1:0] tick_cnt;
  logic [US_W-1:0]   us_cnt;
  logic              tick, timeout;
  logic [5:0]        bit_cnt;
  logic [39:0]       frame;
  logic [1:0]        req_q, req_sel;
  logic [7:0]        retry_cnt;
  logic [7:0]        data_sum;
  logic              accept, fail, success, shift_bit;
  logic              can_retry, cks_ok, err_final, bit_val;

`ifdef CACHE_EN
  localparam int MS_DIV = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
  localparam logic [31:0] MS_LAST   = 32'(MS_DIV - 1);
  localparam logic [31:0] AGE_LIMIT = 32'(MIN_INTERVAL_MS);

  logic        cache_valid;
  logic [31:0] ms_cnt, age_ms;

  // Age of the cached frame in ms, saturating; any failed attempt drops the cache.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cache_valid <= 1'b0;
      ms_cnt      <= '0;
      age_ms      <= '0;
    end else if (success) begin
      cache_valid <= 1'b1;
      ms_cnt      <= '0;
      age_ms      <= '0;
    end else begin
      if (fail) cache_valid <= 1'b0;
      if (ms_cnt == MS_LAST) begin
        ms_cnt <= '0;
        if (age_ms != AGE_LIMIT) age_ms <= age_ms + 32'd1;
      end else begin
        ms_cnt <= ms_cnt + 32'd1;
      end
    end
  end
`endif

  assign rise      = sync[1] & ~sync[2];
  assign fall      = ~sync[1] & sync[2];
  assign tick      = (tick_cnt == TICK_LAST);
  assign timeout   = tick && (us_cnt == TIMEOUT_LAST);
  assign bit_val   = (us_cnt > THRESH);
  assign data_sum  = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
  assign cks_ok    = (data_sum == frame[7:0]);
  assign can_retry = (retry_cnt < RETRY_MAX);
  assign err_final = fail & ~can_retry;
  assign req_sel   = accept ? request : req_q;

  assign dht_data  = (state == START_LOW) ? 1'b0 : 1'bz;
  assign busy      = (state != IDLE) && (state != DONE);
  assign done      = (state == DONE);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    fail       = 1'b0;
    success    = 1'b0;
    shift_bit  = 1'b0;
    if (state != IDLE && !enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (enable && request != 2'b00) begin
          accept     = 1'b1;
          state_next = START_LOW;
`ifdef CACHE_EN
          if (cache_valid && age_ms < AGE_LIMIT) state_next = DONE;
`endif
        end
        START_LOW:  if (tick && us_cnt == START_LAST) state_next = RELEASE;
        RELEASE:    if (fall) state_next = RESP_LOW;  else if (timeout) fail = 1'b1;
        RESP_LOW:   if (rise) state_next = RESP_HIGH; else if (timeout) fail = 1'b1;
        RESP_HIGH:  if (fall) state_next = BIT_LOW;   else if (timeout) fail = 1'b1;
        BIT_LOW:    if (rise) state_next = BIT_HIGH;  else if (timeout) fail = 1'b1;
        BIT_HIGH: begin
          if (fall) begin
            shift_bit  = 1'b1;
            state_next = (bit_cnt == 6'd39) ? CHECK : BIT_LOW;
          end else if (timeout) begin
            fail = 1'b1;
          end
        end
        CHECK: begin
          if (cks_ok) begin
            success    = 1'b1;
            state_next = DONE;
          end else begin
            fail = 1'b1;
          end
        end
        RETRY_WAIT: if (tick && us_cnt == RETRY_LAST) state_next = START_LOW;
        DONE:       state_next = IDLE;
        default:    state_next = IDLE;
      endcase
      if (fail) state_next = can_retry ? RETRY_WAIT : DONE;
    end
  end

  // Results are loaded on the edge into DONE so they are valid while done is high.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sync      <= 3'b111;
      tick_cnt  <= '0;
      us_cnt    <= '0;
      bit_cnt   <= '0;
      frame     <= '0;
      req_q     <= '0;
      retry_cnt <= '0;
      err       <= 1'b0;
      result    <= '0;
      check_sum <= '0;
    end else begin
      sync <= {sync[1:0], dht_data};
      if (state_next != state) begin
        tick_cnt <= '0;
        us_cnt   <= '0;
      end else if (tick) begin
        tick_cnt <= '0;
        us_cnt   <= us_cnt + 1'b1;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end
      if (accept) begin
        req_q     <= request;
        err       <= 1'b0;
        retry_cnt <= 8'd0;
      end
      if (state_next == START_LOW && state != START_LOW) bit_cnt <= 6'd0;
      if (shift_bit) begin
        frame   <= {frame[38:0], bit_val};
        bit_cnt <= bit_cnt + 6'd1;
      end
      if (fail) begin
        if (can_retry) retry_cnt <= retry_cnt + 8'd1;
        else           err       <= 1'b1;
      end
      if (state_next == DONE && state != DONE) begin
        check_sum <= frame[7:0];
        if (req_sel == 2'b11)
          result <= {7'b0, err_final, accept ? 8'd0 : retry_cnt};
        else if (!err_final)
          result <= (req_sel == 2'b01) ? frame[23:8] : frame[39:24];
      end
    end
  end

endmodule

// File: tb/tb_dht_reader.sv
// Scoreboard bench for dht_reader with a behavioural DHT sensor on the open-drain line.
module tb_dht_reader;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [1:0]  request;
  wire         dht_data;
  logic        busy, done, err;
  logic [15:0] result;
  logic [7:0]  check_sum;

  logic        sens_low = 1'b0;
  logic        sens_mode = 1'b0;
  logic        sens_busy = 1'b0;
  logic [39:0] sens_frame = '0;
  int          sens_bit = -1;
  int          start_pulses = 0, last_low = 0, low_run = 0;

  typedef struct {
    logic [15:0] res;
    logic [7:0]  cs;
    logic        chk_cs;
    logic        e;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0, n_miss = 0, done_seen = 0;

  assign dht_data = sens_low ? 1'b0 : 1'bz;
  pullup (dht_data);

  always #5 clock = ~clock;

  dht_reader #(
    .CLK_HZ(1000000), .START_LOW_US(20), .BIT_THRESH_US(40),
    .TIMEOUT_US(200), .MAX_RETRIES(2), .MIN_INTERVAL_MS(5)
  ) dut (
    .clock(clock), .rst_n(rst_n), .enable(enable), .request(request),
    .dht_data(dht_data), .busy(busy), .done(done), .err(err),
    .result(result), .check_sum(check_sum)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_miss++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Sensor answer: 80 us low, 80 us high, then 40 bits of 50 us low + 26/70 us high.
  task automatic sendFrame(input logic [39:0] f);
    sens_busy = 1'b1;
    repeat (30) @(negedge clock);
    sens_low = 1'b1; repeat (80) @(negedge clock);
    sens_low = 1'b0; repeat (80) @(negedge clock);
    for (int i = 0; i < 40; i++) begin
      sens_bit = i;
      sens_low = 1'b1; repeat (50) @(negedge clock);
      sens_low = 1'b0; repeat (f[39-i] ? 70 : 26) @(negedge clock);
    end
    sens_low = 1'b1; repeat (50) @(negedge clock);
    sens_low = 1'b0;
    sens_bit = -1;
    sens_busy = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (dht_data === 1'b0 && !sens_low) begin
        low_run++;
      end else if (low_run > 0) begin
        start_pulses++;
        last_low = low_run;
        low_run = 0;
        if (sens_mode) sendFrame(sens_frame);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (rst_n === 1'b1 && done === 1'b1) begin
        exp_t e;
        done_seen++;
        checkOutput("busy_low_at_done", 32'(busy), 32'd0);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("[TB] FAIL unexpected_done: got done=1, expected no done pulse");
        end else begin
          e = exp_q.pop_front();
          checkOutput("result", 32'(result), 32'(e.res));
          checkOutput("err", 32'(err), 32'(e.e));
          if (e.chk_cs) checkOutput("check_sum", 32'(check_sum), 32'(e.cs));
        end
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] req, input logic [15:0] exp_res, input logic [7:0] exp_cs,
                               input logic chk_cs, input logic exp_err, input int budget, output int cycles);
    exp_t e;
    int   guard;
    guard = 0;
    while (sens_busy && guard < 10000) begin
      @(negedge clock);
      guard++;
    end
    e.res = exp_res;
    e.cs = exp_cs;
    e.chk_cs = chk_cs;
    e.e = exp_err;
    exp_q.push_back(e);
    @(negedge clock);
    request = req;
    @(negedge clock);
    request = 2'b00;
    cycles = 1;
    while (done !== 1'b1 && cycles < budget) begin
      @(negedge clock);
      cycles++;
    end
    if (done !== 1'b1) begin
      n_vec++;
      n_miss++;
      $display("[TB] FAIL done_timeout: got no done within %0d cycles, expected done", budget);
      void'(exp_q.pop_back());
    end else begin
      @(negedge clock);
      checkOutput("done_one_cycle", 32'(done), 32'd0);
    end
  endtask

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc, sp, ds, guard;
    rst_n = 1'b0;
    enable = 1'b0;
    request = 2'b00;
    repeat (3) @(negedge clock);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);
    checkOutput("reset_result", 32'(result), 32'd0);
    checkOutput("reset_check_sum", 32'(check_sum), 32'd0);
    checkOutput("reset_line_released", 32'(dht_data), 32'd1);
    rst_n = 1'b1;
    enable = 1'b1;
    @(negedge clock);

    $display("[TB] good frame, temperature");
    sens_frame = 40'h37_00_19_05_55;
    sens_mode = 1'b1;
    sp = start_pulses;
    applyStimulus(2'b01, 16'h1905, 8'h55, 1'b1, 1'b0, 8000, cyc);
    checkOutput("temp_start_pulses", 32'(start_pulses - sp), 32'd1);
    checkOutput("start_low_cycles", 32'(last_low), 32'd20);

    $display("[TB] good frame, humidity");
    applyStimulus(2'b10, 16'h3700, 8'h55, 1'b1, 1'b0, 8000, cyc);

    $display("[TB] corrupted checksum with retries");
    sens_frame = 40'h37_00_19_05_54;
    sp = start_pulses;
    applyStimulus(2'b01, 16'h3700, 8'h54, 1'b1, 1'b1, 20000, cyc);
    checkOutput("cks_retry_start_pulses", 32'(start_pulses - sp), 32'd3);

    $display("[TB] status after good frame");
    sens_frame = 40'h37_00_19_05_55;
    applyStimulus(2'b11, 16'h0000, 8'h55, 1'b1, 1'b0, 8000, cyc);

    $display("[TB] silent sensor");
    sens_mode = 1'b0;
    sp = start_pulses;
    applyStimulus(2'b01, 16'h0000, 8'h00, 1'b0, 1'b1, 5000, cyc);
    checkOutput("silent_start_pulses", 32'(start_pulses - sp), 32'd3);
    checkOutput("silent_duration_window", 32'(cyc >= 2600 && cyc <= 2720), 32'd1);
    applyStimulus(2'b11, 16'h0102, 8'h00, 1'b0, 1'b1, 5000, cyc);

    $display("[TB] enable drop during bit 17");
    sens_mode = 1'b1;
    ds = done_seen;
    @(negedge clock);
    request = 2'b01;
    @(negedge clock);
    request = 2'b00;
    checkOutput("busy_after_accept", 32'(busy), 32'd1);
    guard = 0;
    while (sens_bit != 16 && guard < 5000) begin
      @(negedge clock);
      guard++;
    end
    checkOutput("reached_bit17", 32'(sens_bit), 32'd16);
    enable = 1'b0;
    @(negedge clock);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_err_unchanged", 32'(err), 32'd0);
    guard = 0;
    while (sens_busy && guard < 5000) begin
      @(negedge clock);
      guard++;
    end
    checkOutput("abort_no_done", 32'(done_seen - ds), 32'd0);
    enable = 1'b1;

    $display("[TB] async reset during start pulse");
    sens_mode = 1'b0;
    @(negedge clock);
    request = 2'b01;
    @(negedge clock);
    request = 2'b00;
    repeat (8) @(negedge clock);
    checkOutput("start_low_driving", 32'(dht_data), 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_line_released", 32'(dht_data), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_result", 32'(result), 32'd0);
    checkOutput("rst_check_sum", 32'(check_sum), 32'd0);
    @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);

    $display("[TB] recovery read");
    sens_mode = 1'b1;
    applyStimulus(2'b01, 16'h1905, 8'h55, 1'b1, 1'b0, 8000, cyc);

`ifdef CACHE_EN
    $display("[TB] cached humidity request");
    sp = start_pulses;
    applyStimulus(2'b10, 16'h3700, 8'h55, 1'b1, 1'b0, 100, cyc);
    checkOutput("cache_latency_ok", 32'(cyc <= 2), 32'd1);
    checkOutput("cache_no_bus", 32'(start_pulses - sp), 32'd0);
    repeat (6000) @(negedge clock);
    sp = start_pulses;
    applyStimulus(2'b10, 16'h3700, 8'h55, 1'b1, 1'b0, 8000, cyc);
    checkOutput("cache_expired_bus", 32'(start_pulses - sp), 32'd1);
`endif

    repeat (5) @(negedge clock);
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
